// File: rtl/chip_test_sequencer.sv
// Sequencer that launches one of NUM_CHIPS attached chip testers from a user Run button,
// waits for its Done (or a timeout) and holds the pass/fail result on display.
module chip_test_sequencer #(
    parameter int NUM_CHIPS      = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [2:0]           Chip_Sel,
    output logic [NUM_CHIPS-1:0] Tst_Run,
    input  logic [NUM_CHIPS-1:0] Tst_Done,
    input  logic [NUM_CHIPS-1:0] Tst_RSLT,
    output logic [NUM_CHIPS-1:0] Tst_DISP,
    output logic                 Busy,
    output logic                 Done,
    output logic                 RSLT,
    output logic                 Timeout,
    output logic                 Sel_Err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DISPLAY
    } state_t;

    state_t               state;
    logic                 run_q;
    logic [2:0]           sel_q;
    logic [CNT_W-1:0]     cnt;

    logic                 run_edge;
    logic                 sel_ok;
    logic [NUM_CHIPS-1:0] sel_onehot;
    logic [NUM_CHIPS-1:0] sel_mask;
    logic                 done_hit;
    logic                 rslt_hit;

    // Masking with the latched select keeps every other tester's Done/RSLT out of the decision.
    assign run_edge   = Run & ~run_q;
    assign sel_ok     = ({1'b0, Chip_Sel} < 4'(NUM_CHIPS));
    assign sel_onehot = NUM_CHIPS'(1) << Chip_Sel;
    assign sel_mask   = NUM_CHIPS'(1) << sel_q;
    assign done_hit   = |(Tst_Done & sel_mask);
    assign rslt_hit   = |(Tst_RSLT & sel_mask);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            run_q    <= 1'b1;
            sel_q    <= '0;
            cnt      <= '0;
            Tst_Run  <= '0;
            Tst_DISP <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            RSLT     <= 1'b0;
            Timeout  <= 1'b0;
            Sel_Err  <= 1'b0;
        end else begin
            run_q <= Run;
            case (state)
                S_IDLE, S_DISPLAY: begin
                    if (run_edge) begin
                        sel_q    <= Chip_Sel;
                        RSLT     <= 1'b0;
                        Timeout  <= 1'b0;
                        Sel_Err  <= 1'b0;
                        Tst_DISP <= '0;
                        if (sel_ok) begin
                            state   <= S_LAUNCH;
                            Tst_Run <= sel_onehot;
                            Busy    <= 1'b1;
                            Done    <= 1'b0;
                        end else begin
                            state   <= S_DISPLAY;
                            Sel_Err <= 1'b1;
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                        end
                    end
                end
                // Done is not looked at here, so a stale Done from an earlier run cannot complete this one.
                S_LAUNCH: begin
                    Tst_Run <= '0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_hit) begin
                        state    <= S_DISPLAY;
                        RSLT     <= rslt_hit;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Tst_DISP <= sel_mask;
                    end else if (cnt == CNT_LAST) begin
                        state    <= S_DISPLAY;
                        RSLT     <= 1'b0;
                        Timeout  <= 1'b1;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Tst_DISP <= sel_mask;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a transaction-level reference model.
module tb_chip_test_sequencer;

    localparam int NC = 6;
    localparam int TO = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Run;
    logic [2:0]    Chip_Sel;
    logic [NC-1:0] Tst_Run;
    logic [NC-1:0] Tst_Done;
    logic [NC-1:0] Tst_RSLT;
    logic [NC-1:0] Tst_DISP;
    logic          Busy;
    logic          Done;
    logic          RSLT;
    logic          Timeout;
    logic          Sel_Err;

    int checks = 0;
    int errors = 0;

    chip_test_sequencer #(.NUM_CHIPS(NC), .TIMEOUT_CYCLES(TO)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Chip_Sel (Chip_Sel),
        .Tst_Run  (Tst_Run),
        .Tst_Done (Tst_Done),
        .Tst_RSLT (Tst_RSLT),
        .Tst_DISP (Tst_DISP),
        .Busy     (Busy),
        .Done     (Done),
        .RSLT     (RSLT),
        .Timeout  (Timeout),
        .Sel_Err  (Sel_Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks "a test is launching / running / showing a result" and
    // the result fields, derived directly from the behavioural rules.
    bit            m_valid = 0;
    bit            m_run_prev;
    bit            m_launching, m_running;
    int            m_sel, m_elapsed;
    logic [NC-1:0] e_run, e_disp;
    bit            e_done, e_rslt, e_to, e_serr;

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid = 1; m_run_prev = 1; m_launching = 0; m_running = 0;
            m_sel = 0; m_elapsed = 0;
            e_run = '0; e_disp = '0; e_done = 0; e_rslt = 0; e_to = 0; e_serr = 0;
        end else if (m_valid) begin
            bit pressed;
            pressed = Run && !m_run_prev;
            m_run_prev = Run;
            if (m_launching) begin
                m_launching = 0; m_running = 1; m_elapsed = 0; e_run = '0;
            end else if (m_running) begin
                if (Tst_Done[m_sel]) begin
                    m_running = 0; e_done = 1; e_rslt = Tst_RSLT[m_sel]; e_disp = NC'(1 << m_sel);
                end else if (m_elapsed == TO - 1) begin
                    m_running = 0; e_done = 1; e_rslt = 0; e_to = 1; e_disp = NC'(1 << m_sel);
                end else begin
                    m_elapsed++;
                end
            end else if (pressed) begin
                m_sel = int'(Chip_Sel);
                e_rslt = 0; e_to = 0; e_serr = 0; e_disp = '0;
                if (m_sel < NC) begin
                    m_launching = 1; e_run = NC'(1 << m_sel); e_done = 0;
                end else begin
                    e_serr = 1; e_done = 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            check("tst_run", 8'(Tst_Run), 8'(e_run));
            check("tst_disp", 8'(Tst_DISP), 8'(e_disp));
            check("busy", 8'(Busy), 8'(m_launching || m_running));
            check("done", 8'(Done), 8'(e_done));
            check("rslt", 8'(RSLT), 8'(e_rslt));
            check("timeout", 8'(Timeout), 8'(e_to));
            check("sel_err", 8'(Sel_Err), 8'(e_serr));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic press(input logic [2:0] sel);
        Chip_Sel = sel; Run = 1'b1; tick(1); Run = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        Reset = 1'b1; Run = 1'b0; Chip_Sel = '0; Tst_Done = '0; Tst_RSLT = '0;
        tick(2);
        check("reset_busy", 8'(Busy), 8'h00);
        check("reset_disp", 8'(Tst_DISP), 8'h00);
        Reset = 1'b0;
        tick(1);

        // Pass path on tester 3
        press(3'd3);
        check("pass_pulse", 8'(Tst_Run), 8'h08);
        tick(1);
        check("pass_pulse_gone", 8'(Tst_Run), 8'h00);
        tick(4);
        Tst_Done = 6'b001000; Tst_RSLT = 6'b001000;
        tick(1);
        Tst_Done = '0; Tst_RSLT = '0;
        check("pass_done", 8'(Done), 8'h01);
        check("pass_rslt", 8'(RSLT), 8'h01);
        check("pass_disp", 8'(Tst_DISP), 8'h08);
        check("pass_to", 8'(Timeout), 8'h00);
        tick(3);
        check("pass_hold", 8'(Tst_DISP), 8'h08);

        // Isolation: only the selected tester's Done counts
        press(3'd2);
        tick(1);
        Tst_Done = 6'b100000; Tst_RSLT = 6'b100000;
        tick(2);
        check("iso_still_busy", 8'(Busy), 8'h01);
        Tst_Done = 6'b000100; Tst_RSLT = 6'b100000;
        tick(1);
        Tst_Done = '0; Tst_RSLT = '0;
        check("iso_done", 8'(Done), 8'h01);
        check("iso_rslt", 8'(RSLT), 8'h00);
        check("iso_disp", 8'(Tst_DISP), 8'h04);

        // Timeout on tester 0
        press(3'd0);
        tick(1);
        n = 0;
        while (!Done && n < 40) begin tick(1); n++; end
        check("to_cycles", 8'(n), 8'd16);
        check("to_flag", 8'(Timeout), 8'h01);
        check("to_rslt", 8'(RSLT), 8'h00);
        check("to_disp", 8'(Tst_DISP), 8'h01);

        // Invalid select
        press(3'd7);
        check("serr_flag", 8'(Sel_Err), 8'h01);
        check("serr_done", 8'(Done), 8'h01);
        check("serr_disp", 8'(Tst_DISP), 8'h00);
        check("serr_run", 8'(Tst_Run), 8'h00);

        // Extra Run edge mid-wait; Done coincides with the timeout cycle
        pulses = 0;
        press(3'd1);
        if (Tst_Run != '0) pulses++;
        tick(1);
        for (int k = 0; k < 15; k++) begin
            Run = (k >= 3 && k < 5);
            if (Tst_Run != '0) pulses++;
            tick(1);
        end
        Run = 1'b0;
        Tst_Done = 6'b000010; Tst_RSLT = 6'b000010;
        tick(1);
        Tst_Done = '0; Tst_RSLT = '0;
        check("coinc_pulses", 8'(pulses), 8'd1);
        check("coinc_rslt", 8'(RSLT), 8'h01);
        check("coinc_to", 8'(Timeout), 8'h00);

        // Reset mid-wait with Run held through reset
        press(3'd4);
        tick(3);
        Reset = 1'b1; Run = 1'b1;
        tick(1);
        Reset = 1'b0;
        Tst_Done = 6'b010000; Tst_RSLT = 6'b010000;
        tick(1);
        Tst_Done = '0; Tst_RSLT = '0;
        check("rst_done", 8'(Done), 8'h00);
        check("rst_busy", 8'(Busy), 8'h00);
        tick(3);
        check("rst_held_run", 8'(Busy), 8'h00);
        Run = 1'b0; tick(1);
        press(3'd4);
        check("rst_restart", 8'(Tst_Run), 8'h10);
        tick(2);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) Run = ~Run;
            Chip_Sel = 3'($urandom_range(0, 7));
            for (int b = 0; b < NC; b++) Tst_Done[b] = ($urandom_range(0, 29) == 0);
            Tst_RSLT = NC'($urandom);
            tick(1);
        end
        Reset = 1'b0; Run = 1'b0; Tst_Done = '0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
